// File: rtl/router_pkg.sv
// Shared definitions for the packet-aware router FIFO: header field layout,
// default geometry, the stored-entry format and a constant clog2 helper.
package router_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;

    // One stored word: header tag on top of the data byte.
    typedef struct packed {
        logic                  hdr_tag;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// combinational read port. The array itself is never reset.
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: stores header-tagged bytes, tracks packet
// length on read and marks start/end of packet, with occupancy flags.
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LEN_MSB   = HDR_LEN_MSB,
    parameter int LEN_LSB   = HDR_LEN_LSB,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] datain,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic [DATA_W-1:0] dataout,
    output logic              dout_valid,
    output logic              sop,
    output logic              eop
);

    localparam int PW = LEN_MSB - LEN_LSB + 2;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C     = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   AE_C     = (AW+1)'(AE_THRESH);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PKT_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0]   pkt_cnt;
    logic [DATA_W:0] rd_word;
    logic            wr_acc, rd_acc;

    // Handshake: a write is taken when write_enb is high and full is low, a
    // read when read_enb is high and empty is low, both judged on the state
    // before the edge; soft_reset overrides both and nothing is taken.
    assign wr_acc = write_enb && !full;
    assign rd_acc = read_enb && !empty;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_acc) wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr_nxt = rd_ptr + PTR_ONE;
    end

    router_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !soft_reset),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({lfd_state, datain}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_cnt    <= '0;
            overflow   <= 1'b0;
            dataout    <= '0;
            dout_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_cnt    <= '0;
            overflow   <= 1'b0;
            dataout    <= '0;
            dout_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            // Pointer difference wraps correctly thanks to the extra MSB.
            count  <= wr_ptr_nxt - rd_ptr_nxt;
            if (write_enb && full) begin
                overflow <= 1'b1;
            end
            dout_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            if (rd_acc) begin
                if (rd_word[DATA_W]) begin
                    // Length field counts payload only; +1 covers the parity byte.
                    pkt_cnt    <= {1'b0, rd_word[LEN_MSB:LEN_LSB]} + PKT_ONE;
                    dataout    <= rd_word[DATA_W-1:0];
                    dout_valid <= 1'b1;
                    sop        <= 1'b1;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt    <= pkt_cnt - PKT_ONE;
                    dataout    <= rd_word[DATA_W-1:0];
                    dout_valid <= 1'b1;
                    eop        <= (pkt_cnt == PKT_ONE);
                end else begin
                    dataout    <= '0;
                end
            end
        end
    end

endmodule
